// File: rtl/press_decoder.sv
// press_decoder: single/double press classifier with a BCD event counter.
// Optional counter is built only when PRESS_DECODER_COUNT_EN is defined.
module press_decoder #(
   parameter int WINDOW_MAX = 12_500_000,
   parameter int TW         = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        press_in,
   output logic        single_out,
   output logic        double_out,
   output logic        busy,
   output logic [15:0] count_bcd
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [TW-1:0] LP_WMAX = TW'(WINDOW_MAX);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic          r_single;
   logic          r_double;
   logic          r_busy;
   logic          w_single_nxt;
   logic          w_double_nxt;

   // Next-state decode; timer only advances while waiting.
   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = '0;
      w_single_nxt = 1'b0;
      w_double_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (press_in) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Timer never passes LP_WMAX, so any press here is a double.
            if (press_in) begin
               w_state_nxt  = S_IDLE;
               w_double_nxt = 1'b1;
            end else if (r_timer == LP_WMAX) begin
               w_state_nxt  = S_IDLE;
               w_single_nxt = 1'b1;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, timer and registered event outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_single <= w_single_nxt;
         r_double <= w_double_nxt;
         r_busy   <= (w_state_nxt == S_WAIT);
      end
   end

   assign single_out = r_single;
   assign double_out = r_double;
   assign busy       = r_busy;

`ifdef PRESS_DECODER_COUNT_EN
   logic [15:0] r_count;
   logic [15:0] w_count_inc;
   logic [15:0] w_count_dec;

   // Per-digit BCD increment and decrement with ripple carry/borrow.
   always_comb begin
      logic w_c;
      logic w_b;
      w_count_inc = r_count;
      w_count_dec = r_count;
      w_c         = 1'b1;
      w_b         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_c) begin
            if (r_count[4*i +: 4] >= 4'd9) begin
               w_count_inc[4*i +: 4] = 4'd0;
            end else begin
               w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_c = 1'b0;
            end
         end
         if (w_b) begin
            if (r_count[4*i +: 4] == 4'd0) begin
               w_count_dec[4*i +: 4] = 4'd9;
            end else begin
               w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
               w_b = 1'b0;
            end
         end
      end
   end

   // Counter moves on the same edge that raises the event pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= 16'h0000;
      end else if (w_single_nxt) begin
         r_count <= w_count_inc;
      end else if (w_double_nxt) begin
         r_count <= w_count_dec;
      end
   end

   assign count_bcd = r_count;
`else
   assign count_bcd = 16'h0000;
`endif

endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: directed self-checking bench for press_decoder.
// Expected count follows PRESS_DECODER_COUNT_EN (zero when not built).
module tb_press_decoder;

   localparam int W = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        press_in = 1'b0;
   logic        single_out;
   logic        double_out;
   logic        busy;
   logic [15:0] count_bcd;

   int checks = 0;
   int failures = 0;
   int cnt = 0;

   press_decoder #(
      .WINDOW_MAX(W),
      .TW(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .press_in(press_in),
      .single_out(single_out),
      .double_out(double_out),
      .busy(busy),
      .count_bcd(count_bcd)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bcd(input int v);
`ifdef PRESS_DECODER_COUNT_EN
      return {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
`else
      return 16'h0000 & 16'(v);
`endif
   endfunction

   task automatic chk_out(input string tag, input logic s,
                          input logic d, input logic b);
      chk(tag, {29'd0, single_out, double_out, busy}, {29'd0, s, d, b});
   endtask

   task automatic chk_cnt(input string tag);
      chk(tag, {16'd0, count_bcd}, {16'd0, bcd(cnt)});
   endtask

   task automatic press();
      press_in = 1'b1;
      tick();
      press_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      press_in = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      cnt = 0;
   endtask

   // First press at edge 0; single pulse observed in cycle 22.
   task automatic single_seq(input string tag, input bit full);
      press();
      for (int i = 1; i <= W + 1; i++) begin
         if (full) chk_out({tag, "_wait"}, 1'b0, 1'b0, 1'b1);
         tick();
      end
      cnt = (cnt + 1) % 10000;
      chk_out({tag, "_evt"}, 1'b1, 1'b0, 1'b0);
      chk_cnt({tag, "_cnt"});
      tick();
      chk_out({tag, "_after"}, 1'b0, 1'b0, 1'b0);
   endtask

   // Presses at edges 0 and gap; double pulse observed in cycle gap+1.
   task automatic double_seq(input string tag, input int gap);
      press();
      for (int i = 1; i < gap; i++) begin
         chk_out({tag, "_wait"}, 1'b0, 1'b0, 1'b1);
         tick();
      end
      press();
      cnt = (cnt + 9999) % 10000;
      chk_out({tag, "_evt"}, 1'b0, 1'b1, 1'b0);
      chk_cnt({tag, "_cnt"});
      tick();
      chk_out({tag, "_after"}, 1'b0, 1'b0, 1'b0);
   endtask

   // Directed sequence.
   initial begin
      rst_n = 1'b0;
      repeat (2) tick();
      press_in = 1'b1;
      tick();
      press_in = 1'b0;
      chk_out("rst_out", 1'b0, 1'b0, 1'b0);
      chk_cnt("rst_cnt");
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         chk("idle", {13'd0, single_out, double_out, busy, count_bcd}, 32'd0);
         tick();
      end

      single_seq("single", 1'b1);
      repeat (4) single_seq("fill", 1'b0);
      double_seq("dbl10", 10);

      press();
      repeat (4) tick();
      press();
      cnt = (cnt + 9999) % 10000;
      chk_out("evtpress_dbl", 1'b0, 1'b1, 1'b0);
      press();
      chk_out("evtpress_start", 1'b0, 1'b0, 1'b1);
      repeat (W + 1) tick();
      cnt = (cnt + 1) % 10000;
      chk_out("evtpress_single", 1'b1, 1'b0, 1'b0);
      chk_cnt("evtpress_cnt");
      tick();

      double_seq("dbl21", W + 1);

      press();
      repeat (W + 1) tick();
      cnt = (cnt + 1) % 10000;
      chk_out("b22_first", 1'b1, 1'b0, 1'b0);
      chk_cnt("b22_cnt1");
      press();
      chk_out("b22_restart", 1'b0, 1'b0, 1'b1);
      repeat (W + 1) tick();
      cnt = (cnt + 1) % 10000;
      chk_out("b22_second", 1'b1, 1'b0, 1'b0);
      chk_cnt("b22_cnt2");
      tick();
      chk_out("b22_after", 1'b0, 1'b0, 1'b0);

      do_reset();
      chk_cnt("wrap_rst");
      double_seq("wrap_dn", 3);
      single_seq("wrap_up", 1'b0);
      repeat (99) single_seq("to99", 1'b0);
      chk_cnt("at_0099");
      single_seq("to100", 1'b0);

      press();
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      cnt = 0;
      chk_out("midrst_out", 1'b0, 1'b0, 1'b0);
      chk_cnt("midrst_cnt");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("midrst_quiet", 1'b0, 1'b0, 1'b0);
      end
      press();
      for (int i = 0; i <= W; i++) begin
         chk_out("midrst_wait", 1'b0, 1'b0, 1'b1);
         tick();
      end
      cnt = (cnt + 1) % 10000;
      chk_out("midrst_single", 1'b1, 1'b0, 1'b0);
      chk_cnt("midrst_cnt2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/press_decoder.md
# press_decoder

Downstream consumer of the button debouncer's single-cycle press pulses. Classifies each press sequence as a single or double press using a configurable time window, emits one-cycle event pulses, and maintains a 4-digit BCD value for the display controller. A single press increments the value; a double press decrements it.

## Interface

Parameters:
- `WINDOW_MAX`, default 12_500_000: last timer value at which a second press still counts as a double. Bench value is 20.
- `TW`, default 24: timer width in bits. Must satisfy `2^TW > WINDOW_MAX`.

Ports:
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `press_in` input, 1 bit: one-cycle press pulse from the debouncer.
- `single_out` output, 1 bit: one-cycle pulse marking a completed single press.
- `double_out` output, 1 bit: one-cycle pulse marking a completed double press.
- `busy` output, 1 bit: high while waiting for a possible second press.
- `count_bcd` output, 16 bits: 4 BCD digits, `[15:12]` is the most significant digit.

## Operation

Two-state FSM plus timer. All outputs are registered.

IDLE:
- `timer` is held at 0.
- `press_in`=1 → WAIT, with `timer`=0 on the next cycle.

WAIT (`busy`=1):
- `timer` increments by 1 each cycle.
- `press_in`=1 while `timer` ≤ `WINDOW_MAX` → `double_out`=1 on the next cycle, state returns to IDLE.
- `timer`==`WINDOW_MAX` and `press_in`=0 → `single_out`=1 on the next cycle, state returns to IDLE.
- Simultaneous press and `timer`==`WINDOW_MAX`: the press wins and the sequence is a double.

Event-cycle rules:
- Decoding continues without a dead cycle.
- A press sampled in the cycle where `single_out` or `double_out` is high (state already IDLE) starts a new sequence.

Count:
- `count_bcd` updates on the same edge that raises the event pulse.
- Single: BCD +1, with per-digit carry.
- Double: BCD −1, with per-digit borrow.
- 9999 + 1 = 0000; 0000 − 1 = 9999.
- Digits are never outside 0–9.

Exclusivity: `single_out` and `double_out` are never high together. Each is high for exactly one cycle per sequence.

A third press after a double is not special: it starts a new sequence.

## Timing

- Reset values (`rst_n` low at any edge): state IDLE, `timer`=0, `single_out`=0, `double_out`=0, `busy`=0, `count_bcd`=16'h0000.
- Reset mid-WAIT discards the pending sequence; no event pulse is emitted.
- A press sampled while `rst_n`=0 is ignored.
- `busy` rises the cycle after the first press.
- `busy` falls in the same cycle the event pulse rises.
- Single latency: first press sampled at edge N → `single_out` high at cycle N+`WINDOW_MAX`+2.
- Double latency: second press sampled at edge M → `double_out` high at cycle M+1.
- Latest valid second press: edge N+`WINDOW_MAX`+1.
- A press at edge N+`WINDOW_MAX`+2 begins a new sequence.
- `timer` never exceeds `WINDOW_MAX`, so there is no wrap.

## Configuration

Macro `PRESS_DECODER_COUNT_EN`:
- Defined: the BCD counter is built as described above.
- Undefined: no counter logic is built; `count_bcd` is constant 16'h0000.
- Event pulses, `busy` and all timing are identical in both builds.

## Test plan

All scenarios use `WINDOW_MAX`=20.

- Reset then idle: hold `rst_n`=0 for 3 cycles, then release with no presses → all outputs 0 and `count_bcd`=0000 for 50 cycles.
- Single press: press at edge 0 → `busy` high during cycles 1–21; `single_out` high only at cycle 22; `count_bcd`=0001.
- Double press: press at edges 0 and 10 → `double_out` high at cycle 11; `single_out` never rises; count 0005 → 0004.
- Window boundary:
  - Presses at edges 0 and 21 → double.
  - Presses at edges 0 and 22 → `single_out` at 22, then a new sequence from 22; with no further press, a second `single_out` at 44.
- Wrap:
  - From 0000, a double press → 9999.
  - From 9999, a single press → 0000.
  - From 0099, a single press → 0100.
- Reset mid-WAIT: press at edge 0, `rst_n`=0 at edge 8 → no event pulse, `busy`=0, count 0000. A press at edge 12 then yields `single_out` at cycle 34.
